// File: rtl/fnd_scan_if.sv
// Display bus between a host and the FND scan controller: BCD word and blank request in,
// decoder nibble/enable, digit commons and frame tick out.
interface fnd_scan_if;
  logic [15:0] digit_data;
  logic        blank_all;
  logic [3:0]  bcd;
  logic        fnd_blank;
  logic [3:0]  fndcom;
  logic        frame_tick;

  modport master (
    output digit_data,
    output blank_all,
    input  bcd,
    input  fnd_blank,
    input  fndcom,
    input  frame_tick
  );

  modport slave (
    input  digit_data,
    input  blank_all,
    output bcd,
    output fnd_blank,
    output fndcom,
    output frame_tick
  );
endinterface

// File: rtl/fnd_scan_controller.sv
// 4-digit multiplexed 7-segment scan controller with a dead interval per digit and per-frame snapshot.
// Optional leading-zero blanking on digits 3..1 is enabled by defining FND_LEADING_ZERO_BLANK_EN.
module fnd_scan_controller #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1_000,
  parameter int DEAD_CYC = 16
) (
  input  logic      i_clk,
  input  logic      i_reset,
  fnd_scan_if.slave bus
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] P_LAST     = PW'(DIV - 1);
  localparam logic [PW-1:0] P_DEAD_END = PW'(DEAD_CYC - 1);

  typedef enum logic {
    DEAD  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t         state_r;
  logic [PW-1:0]  presc_r;
  logic [1:0]     idx_r;
  logic [15:0]    snap_r;
  logic [3:0]     bcd_r;
  logic           fnd_blank_r;
  logic [3:0]     fndcom_r;
  logic           frame_tick_r;

  logic           wrap_s;
  logic [PW-1:0]  presc_next_s;
  logic [1:0]     idx_next_s;
  logic [15:0]    snap_next_s;
  logic           lead_zero_s;

  function automatic logic [3:0] sel_nibble(input logic [15:0] snap, input logic [1:0] idx);
    case (idx)
      2'd0:    sel_nibble = snap[3:0];
      2'd1:    sel_nibble = snap[7:4];
      2'd2:    sel_nibble = snap[11:8];
      2'd3:    sel_nibble = snap[15:12];
      default: sel_nibble = 4'h0;
    endcase
  endfunction

`ifdef FND_LEADING_ZERO_BLANK_EN
  // A digit is suppressed when it and every more significant digit are zero; digit 0 always shows.
  function automatic logic lead_zero(input logic [15:0] snap, input logic [1:0] idx);
    case (idx)
      2'd3:    lead_zero = (snap[15:12] == 4'h0);
      2'd2:    lead_zero = (snap[15:8]  == 8'h00);
      2'd1:    lead_zero = (snap[15:4]  == 12'h000);
      default: lead_zero = 1'b0;
    endcase
  endfunction
`endif

  // Next prescaler, digit index and frame snapshot; the snapshot refreshes only as idx wraps to 0.
  always_comb begin
    wrap_s       = (presc_r == P_LAST);
    presc_next_s = presc_r + PW'(1);
    idx_next_s   = idx_r;
    snap_next_s  = snap_r;
    if (wrap_s) begin
      presc_next_s = {PW{1'b0}};
      idx_next_s   = idx_r + 2'd1;
      if (idx_r == 2'd3) begin
        snap_next_s = bus.digit_data;
      end else begin
        snap_next_s = snap_r;
      end
    end else begin
      presc_next_s = presc_r + PW'(1);
      idx_next_s   = idx_r;
      snap_next_s  = snap_r;
    end
`ifdef FND_LEADING_ZERO_BLANK_EN
    lead_zero_s = lead_zero(snap_r, idx_r);
`else
    lead_zero_s = 1'b0;
`endif
  end

  // Scan counters plus DEAD/DRIVE FSM; outputs are computed for the cycle being entered.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r      <= DEAD;
      presc_r      <= {PW{1'b0}};
      idx_r        <= 2'd0;
      snap_r       <= 16'h0000;
      bcd_r        <= 4'h0;
      fnd_blank_r  <= 1'b1;
      fndcom_r     <= 4'hF;
      frame_tick_r <= 1'b0;
    end else begin
      presc_r <= presc_next_s;
      idx_r   <= idx_next_s;
      snap_r  <= snap_next_s;
      // Nibble tracks the upcoming digit so decoder data settles during the dead interval.
      bcd_r   <= sel_nibble(snap_next_s, idx_next_s);
      case (state_r)
        DEAD: begin
          if (presc_r == P_DEAD_END) begin
            state_r      <= DRIVE;
            fndcom_r     <= bus.blank_all ? 4'hF : ~(4'b0001 << idx_r);
            fnd_blank_r  <= bus.blank_all | lead_zero_s;
            frame_tick_r <= (idx_r == 2'd0);
          end else begin
            state_r      <= DEAD;
            fndcom_r     <= 4'hF;
            fnd_blank_r  <= 1'b1;
            frame_tick_r <= 1'b0;
          end
        end
        DRIVE: begin
          if (wrap_s) begin
            state_r      <= DEAD;
            fndcom_r     <= 4'hF;
            fnd_blank_r  <= 1'b1;
            frame_tick_r <= 1'b0;
          end else begin
            state_r      <= DRIVE;
            fndcom_r     <= bus.blank_all ? 4'hF : ~(4'b0001 << idx_r);
            fnd_blank_r  <= bus.blank_all | lead_zero_s;
            frame_tick_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= DEAD;
          fndcom_r     <= 4'hF;
          fnd_blank_r  <= 1'b1;
          frame_tick_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bcd        = bcd_r;
  assign bus.fnd_blank  = fnd_blank_r;
  assign bus.fndcom     = fndcom_r;
  assign bus.frame_tick = frame_tick_r;

endmodule
